pipelined_rca_adder: RTL and testbench
======================================

// Module: pipelined_rca_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor. Next generation of the 32-bit RCA.
//  Splits a WIDTH-bit add into CHUNK-bit ripple slices, one register stage per slice.
//  Uses valid/ready handshakes on input and output, with per-stage bubble collapse.
//  Sits between the operand-issue logic and the result writeback, where a long ripple
//  chain would otherwise break timing.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   8  bits added per pipeline stage; STAGES = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: S=A+B+cin; 1: S=A-B (A + ~B + 1)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  s          out  WIDTH  sum/difference
//  cout       out  1      carry-out (for sub: 1 = no borrow, i.e. A>=B unsigned)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync-safe release):
//    all stage valid bits=0, all data regs=0, so out_valid=0, s=0, cout=0, ovf=0.
//    in_ready=1 from the first cycle after reset.
//  - Beat transfer on input when in_valid&in_ready; on output when out_valid&out_ready.
//  - Stage k (0..STAGES-1):
//    - adds bits [k*CHUNK +: CHUNK] of A and B' (B'=sub ? ~B : B) plus the carry
//      registered by stage k-1.
//    - stage 0 carry-in is sub ? 1 : cin.
//    - registers the chunk sum, its carry-out, all not-yet-added upper operand bits, and
//      the lower sum bits already produced.
//  - Bubble collapse: ready_k = ~valid_k | ready_{k+1}; ready_STAGES = out_ready;
//    in_ready = ready_0. Stage k loads when ready_k; valid_k <= valid_{k-1} (in_valid for k=0).
//  - Latency: exactly STAGES cycles from input handshake to out_valid with no backpressure.
//    Throughput is 1 beat/cycle.
//  - Stall: out_valid=1 & out_ready=0 holds s/cout/ovf stable.
//    Upstream stages keep filling empty slots. in_ready drops only when every stage is valid.
//  - Ordering: results leave strictly in input order. No beat is dropped or duplicated.
//  - Arithmetic: s = (A + B' + c0) mod 2^WIDTH; cout = bit WIDTH of that sum.
//    ovf is taken from the final stage's MSB carries.
//  - sub and cin are sampled with the operands and travel with the beat.
//    Mixed add/sub beats in flight are independent.
//  - Simultaneous load into a full last stage while out handshake fires is legal (pass-through).
//  - rst mid-operation: every in-flight beat is discarded, with no partial result emitted.
//  - in_valid=0: no state change except draining. Operands are ignored unless in_valid.
// TESTING (WIDTH=32, CHUNK=8, STAGES=4)
//  1. Reset, then a=32'h0000_0001, b=32'h0000_0002, cin=0, sub=0, out_ready=1
//     -> after 4 cycles: s=32'h0000_0003, cout=0, ovf=0, one out_valid pulse.
//  2. Cross-chunk carry: a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0
//     -> s=32'h0000_0000, cout=1, ovf=0.
//     Signed overflow: a=32'h7FFF_FFFF, b=1 -> s=32'h8000_0000, ovf=1, cout=0.
//  3. Subtract: a=5, b=7, sub=1, cin=1 (ignored)
//     -> s=32'hFFFF_FFFE, cout=0; a=7, b=5 -> s=2, cout=1.
//  4. Back-to-back stream of 16 beats (a=i, b=3*i) with out_ready=1
//     -> 16 consecutive out_valid cycles, s=4*i in order, in_ready constant 1.
//  5. Backpressure: out_ready=0 while feeding beats
//     -> in_ready falls after 4 accepted beats and output holds stable.
//     Release out_ready -> all 4 results in order, no loss.
//  6. Assert rst with 3 beats in flight
//     -> out_valid=0 immediately, s=0, and no stale result after reset release.

Source files
------------

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple slice per stage,
// valid/ready handshake with per-stage bubble collapse.
module pipelined_rca_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic [WIDTH-1:0] bx;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  cy;

  assign bx        = b ^ {WIDTH{sub}};
  assign vld[0]    = in_valid;
  assign cy[0]     = sub | cin;
  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign cout      = cy[STAGES];

  // A stage can load when it is empty or its successor frees up this cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld[k+1] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RI = WIDTH - k * CHUNK;
    localparam int SO = (k + 1) * CHUNK;

    logic [RI-1:0]  ia;
    logic [RI-1:0]  ib;
    logic [SO-1:0]  s_d;
    logic [SO-1:0]  s_q;
    logic [CHUNK:0] add;
    logic           v_q;
    logic           c_q;
    logic           ld;

    if (k == 0) begin : g_src
      assign ia  = a;
      assign ib  = bx;
      assign s_d = add[CHUNK-1:0];
    end else begin : g_src
      assign ia  = g_stg[k-1].g_fwd.a_q;
      assign ib  = g_stg[k-1].g_fwd.b_q;
      assign s_d = {add[CHUNK-1:0], g_stg[k-1].s_q};
    end

    assign add = {1'b0, ia[CHUNK-1:0]}
               + {1'b0, ib[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, cy[k]};
    assign ld  = rdy[k] & vld[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= vld[k];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        c_q <= 1'b0;
        s_q <= '0;
      end else if (ld) begin
        c_q <= add[CHUNK];
        s_q <= s_d;
      end
    end

    assign vld[k+1] = v_q;
    assign cy[k+1]  = c_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [RI-CHUNK-1:0] a_q;
      logic [RI-CHUNK-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= ia[RI-1:CHUNK];
          b_q <= ib[RI-1:CHUNK];
        end
      end
    end else begin : g_out
      logic o_q;

      // Carry into the MSB is recovered from the MSB sum bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          o_q <= 1'b0;
        end else if (ld) begin
          o_q <= ia[CHUNK-1] ^ ib[CHUNK-1]
               ^ add[CHUNK-1] ^ add[CHUNK];
        end
      end

      assign s   = s_q;
      assign ovf = o_q;
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder: queue-based arithmetic model plus
// directed vectors with hand-computed literal results.
module tb_pipelined_rca_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t q[$];
  res_t last = '0;
  res_t held = '0;
  logic stall = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   run = 0;
  int   max_run = 0;
  int   n_wait = 0;

  function automatic res_t model(logic [W-1:0] ta, logic [W-1:0] tb,
                                 logic tc, logic ts);
    logic [W:0]   full;
    logic [W-1:0] bb;
    res_t         r;
    bb   = ts ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
    r.s  = full[W-1:0];
    r.c  = full[W];
    // Signed overflow: same-sign operands giving an opposite-sign result.
    r.o  = (ta[W-1] == bb[W-1]) && (r.s[W-1] != ta[W-1]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare process: inputs only change just after posedge, so negedge is safe.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      stall = 1'b0;
      run   = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_s", s, held.s);
        chk("hold_cout", cout, held.c);
        chk("hold_ovf", ovf, held.o);
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          chk("unexpected_beat", q.size(), 1);
        end else begin
          last = q.pop_front();
          chk("s", s, last.s);
          chk("cout", cout, last.c);
          chk("ovf", ovf, last.o);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      stall = out_valid && !out_ready;
      held  = {s, cout, ovf};
      run   = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    int w;
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", w, 0);
    n_wait += w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 100) chk("drain_timeout", w, 0);
    @(negedge clk);
    #1;
  endtask

  int n;
  int p0;
  int nw0;
  int acc;
  logic hs;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_s", s, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    align();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // 1: simple add, latency and single pulse
    align();
    send(32'h1, 32'h2, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("latency", n, 4);
    chk("t1_s", s, 32'h3);
    chk("t1_cout", cout, 1'b0);
    chk("t1_ovf", ovf, 1'b0);
    @(negedge clk);
    chk("t1_one_pulse", out_valid, 1'b0);

    // 2: carry through every chunk, then signed overflow
    align();
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_drain();
    chk("t2a_s", last.s, 32'h0);
    chk("t2a_cout", last.c, 1'b1);
    chk("t2a_ovf", last.o, 1'b0);
    align();
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_drain();
    chk("t2b_s", last.s, 32'h8000_0000);
    chk("t2b_cout", last.c, 1'b0);
    chk("t2b_ovf", last.o, 1'b1);

    // 3: subtract, cin ignored
    align();
    send(32'd5, 32'd7, 1'b1, 1'b1);
    wait_drain();
    chk("t3a_s", last.s, 32'hFFFF_FFFE);
    chk("t3a_cout", last.c, 1'b0);
    align();
    send(32'd7, 32'd5, 1'b0, 1'b1);
    wait_drain();
    chk("t3b_s", last.s, 32'h2);
    chk("t3b_cout", last.c, 1'b1);

    // 4: back-to-back stream
    align();
    nw0 = n_wait;
    max_run = 0;
    for (int i = 0; i < 16; i++) send(i, 3 * i, 1'b0, 1'b0);
    wait_drain();
    chk("t4_in_ready_stalls", n_wait - nw0, 0);
    chk("t4_run", max_run, 16);
    chk("t4_last_s", last.s, 32'd60);

    // 5: backpressure fills the pipe
    align();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'd100 + acc;
      b = acc;
      cin = 1'b0;
      sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) acc++;
    end
    in_valid = 1'b0;
    chk("t5_accepted", acc, 4);
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1'b0);
    chk("t5_out_valid", out_valid, 1'b1);
    chk("t5_held_s", s, 32'd100);
    align();
    p0 = n_pop;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("t5_drained", n_pop - p0, 4);
    chk("t5_last_s", last.s, 32'd106);
    chk("t5_queue", q.size(), 0);

    // 6: reset with beats in flight
    align();
    for (int i = 0; i < 3; i++) send(32'd1000 + i, i, 1'b0, 1'b0);
    align();
    chk("t6_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_s", s, 32'h0);
    chk("t6_cout", cout, 1'b0);
    align();
    rst = 1'b0;
    p0 = n_pop;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_stale", n_pop - p0, 0);
    chk("t6_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
